// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file.
// Combinational read ports with optional same-cycle write bypass, an optional
// hardwired-zero entry 0, and a clear engine that zeroes one row per cycle
// after reset or on request. While clearing, writes are dropped and reads return 0.
module regfile_param #(
    parameter int WIDTH   = 17,
    parameter int DEPTH   = 7,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wrd,
    input  logic              we,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              busy,
    output logic              clr_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One past the last implemented entry, widened so DEPTH == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic                clr_done_reg;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_data;

    logic [ADDR_W-1:0]   ra_arr [2];
    logic [WIDTH-1:0]    rd_arr [2];

    // True when the address names an implemented entry.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < ADDR_LIM);
    endfunction

    // True when the address is the hardwired-zero entry.
    function automatic logic is_zero_row(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Clear sequencer: reset or a request restarts the sweep at row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR;
            ptr_reg      <= '0;
            clr_done_reg <= 1'b0;
        end else begin
            clr_done_reg <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    if (ptr_reg == LAST_ROW) begin
                        state_reg    <= IDLE;
                        clr_done_reg <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state_reg <= CLEAR;
                        ptr_reg   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_done = clr_done_reg;

    // Single array write port, shared by the clear sweep and normal writes.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr;
        mem_data = wrd;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem_we   = 1'b1;
                mem_addr = ptr_reg;
                mem_data = '0;
            end else if (!clr_req && we && in_range(wr) && !is_zero_row(wr)) begin
                mem_we = 1'b1;
            end
        end
    end

    // Array storage; no reset, the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;

    // Two identical combinational read ports.
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        // Read mux: busy / out-of-range / zero row give 0, else bypass or array.
        always_comb begin
            rd_arr[gi] = '0;
            if (!busy && in_range(ra_arr[gi]) && !is_zero_row(ra_arr[gi])) begin
                if ((BYPASS != 0) && we && !clr_req && (wr == ra_arr[gi])) begin
                    rd_arr[gi] = wrd;
                end else begin
                    rd_arr[gi] = mem[ra_arr[gi]];
                end
            end
        end
    end

    assign rd1 = rd_arr[0];
    assign rd2 = rd_arr[1];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a BYPASS=1 and a BYPASS=0 instance share
// one stimulus set (default 17x7 geometry); a third instance covers the
// 32x16 hardwired-zero configuration.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 17x7 instances
    logic        rst = 1'b1;
    logic [2:0]  ra1 = '0, ra2 = '0, wr = '0;
    logic [16:0] wrd = '0;
    logic        we = 1'b0, clr_req = 1'b0;
    logic [16:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy, a_done, b_busy, b_done;

    // Stimulus for the 32x16 zero-r0 instance
    logic        c_rst = 1'b1;
    logic [3:0]  c_ra1 = '0, c_ra2 = '0, c_wr = '0;
    logic [31:0] c_wrd = '0;
    logic        c_we = 1'b0, c_clr_req = 1'b0;
    logic [31:0] c_rd1, c_rd2;
    logic        c_busy, c_done;

    int total = 0;
    int bad   = 0;

    regfile_param #(.WIDTH(17), .DEPTH(7), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .wr(wr), .wrd(wrd), .we(we),
        .clr_req(clr_req), .rd1(a_rd1), .rd2(a_rd2), .busy(a_busy), .clr_done(a_done));

    regfile_param #(.WIDTH(17), .DEPTH(7), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .wr(wr), .wrd(wrd), .we(we),
        .clr_req(clr_req), .rd1(b_rd1), .rd2(b_rd2), .busy(b_busy), .clr_done(b_done));

    regfile_param #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .BYPASS(1), .ZERO_R0(1)) dut_c (
        .clk(clk), .rst(c_rst), .ra1(c_ra1), .ra2(c_ra2), .wr(c_wr), .wrd(c_wrd), .we(c_we),
        .clr_req(c_clr_req), .rd1(c_rd1), .rd2(c_rd2), .busy(c_busy), .clr_done(c_done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge, then settle inputs well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect busy on both 17x7 instances for exactly n cycles, then the done pulse.
    task automatic expect_ab_clear(input string tag, input int n, input bit poke_req);
        for (int i = 0; i < n; i++) begin
            clr_req = (poke_req && i == 3);
            #1;
            chk({tag, " a_busy"}, 32'(a_busy), 32'd1);
            chk({tag, " b_busy"}, 32'(b_busy), 32'd1);
            chk({tag, " a_done_low"}, 32'(a_done), 32'd0);
            tick();
        end
        clr_req = 1'b0;
        #1;
        chk({tag, " a_busy_end"}, 32'(a_busy), 32'd0);
        chk({tag, " b_busy_end"}, 32'(b_busy), 32'd0);
        chk({tag, " a_done"}, 32'(a_done), 32'd1);
        chk({tag, " b_done"}, 32'(b_done), 32'd1);
        tick();
        chk({tag, " a_done_pulse"}, 32'(a_done), 32'd0);
        chk({tag, " a_still_idle"}, 32'(a_busy), 32'd0);
    endtask

    task automatic expect_ab_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i);
            ra2 = 3'(7 - i);
            #1;
            chk($sformatf("%s a_rd1[%0d]", tag, i), 32'(a_rd1), 32'd0);
            chk($sformatf("%s a_rd2[%0d]", tag, 7 - i), 32'(a_rd2), 32'd0);
            chk($sformatf("%s b_rd1[%0d]", tag, i), 32'(b_rd1), 32'd0);
        end
    endtask

    task automatic write_ab(input logic [2:0] addr, input logic [16:0] data);
        we  = 1'b1;
        wr  = addr;
        wrd = data;
        tick();
        we  = 1'b0;
    endtask

    initial begin
        // Reset: two cycles with rst high
        rst = 1'b1;
        tick();
        tick();
        chk("reset a_busy", 32'(a_busy), 32'd1);
        chk("reset a_done", 32'(a_done), 32'd0);
        chk("reset a_rd1", 32'(a_rd1), 32'd0);
        chk("reset a_rd2", 32'(a_rd2), 32'd0);
        rst = 1'b0;
        expect_ab_clear("init_clear", 7, 1'b0);
        expect_ab_all_zero("post_reset");

        // Basic write / read
        write_ab(3'd3, 17'h1ABCD);
        write_ab(3'd5, 17'h00001);
        ra1 = 3'd3;
        ra2 = 3'd5;
        #1;
        chk("rd r3 a_rd1", 32'(a_rd1), 32'h1ABCD);
        chk("rd r5 a_rd2", 32'(a_rd2), 32'h00001);
        chk("rd r3 b_rd1", 32'(b_rd1), 32'h1ABCD);
        chk("rd r5 b_rd2", 32'(b_rd2), 32'h00001);
        ra2 = 3'd3;
        #1;
        chk("same addr a_rd2", 32'(a_rd2), 32'h1ABCD);

        // Out-of-range address: reads 0, write dropped, no bypass
        ra1 = 3'd7;
        ra2 = 3'd5;
        we  = 1'b1;
        wr  = 3'd7;
        wrd = 17'h1FFFF;
        #1;
        chk("oor bypass a_rd1", 32'(a_rd1), 32'd0);
        tick();
        we = 1'b0;
        #1;
        chk("oor a_rd1", 32'(a_rd1), 32'd0);
        chk("oor keep r5", 32'(a_rd2), 32'h00001);
        ra1 = 3'd3;
        #1;
        chk("oor keep r3", 32'(a_rd1), 32'h1ABCD);

        // Bypass vs no bypass on r2
        write_ab(3'd2, 17'h0AAAA);
        we  = 1'b1;
        wr  = 3'd2;
        wrd = 17'h15555;
        ra1 = 3'd2;
        #1;
        chk("bypass a_rd1", 32'(a_rd1), 32'h15555);
        chk("nobypass b_rd1", 32'(b_rd1), 32'h0AAAA);
        tick();
        we = 1'b0;
        #1;
        chk("after wr a_rd1", 32'(a_rd1), 32'h15555);
        chk("after wr b_rd1", 32'(b_rd1), 32'h15555);

        // Fill r0..r6, then clear request with a colliding write
        for (int i = 0; i < 7; i++) write_ab(3'(i), 17'h100 + 17'(i));
        ra1 = 3'd4;
        ra2 = 3'd0;
        #1;
        chk("fill r4", 32'(a_rd1), 32'h104);
        chk("fill r0", 32'(a_rd2), 32'h100);
        clr_req = 1'b1;
        we  = 1'b1;
        wr  = 3'd4;
        wrd = 17'h12345;
        #1;
        chk("clr_req kills bypass", 32'(a_rd1), 32'h104);
        tick();
        clr_req = 1'b0;
        we = 1'b0;
        expect_ab_clear("req_clear", 7, 1'b1);
        expect_ab_all_zero("post_req_clear");

        // Reset while the sweep is at ptr 3
        write_ab(3'd6, 17'h0F0F0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        chk("mid a_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_ab_clear("mid_reset", 7, 1'b0);

        // 32x16 instance with hardwired-zero r0
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("c busy", 32'(c_busy), 32'd1);
            tick();
        end
        chk("c busy_end", 32'(c_busy), 32'd0);
        chk("c done", 32'(c_done), 32'd1);
        c_we  = 1'b1;
        c_wr  = 4'd0;
        c_wrd = 32'hFFFFFFFF;
        c_ra1 = 4'd0;
        #1;
        chk("c r0 bypass", c_rd1, 32'd0);
        tick();
        c_wr = 4'd15;
        tick();
        c_we  = 1'b0;
        c_ra1 = 4'd0;
        c_ra2 = 4'd15;
        #1;
        chk("c r0", c_rd1, 32'd0);
        chk("c r15", c_rd2, 32'hFFFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: the next generation of the fixed 7x17 two-read/one-write array, generalised in width and depth. Adds optional write-to-read bypass, an optional hardwired-zero entry 0, and a sequential clear engine that zeroes the array one row per cycle after reset or on request. It sits in the datapath as the CPU's register file, feeding both ALU operands and accepting the write-back result.

## Interface
- WIDTH, 17, data bits per entry
- DEPTH, 7, number of implemented entries (2..2^ADDR_W)
- ADDR_W, 3, address width for ra1/ra2/wr
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
- ZERO_R0, 0, 1 = entry 0 reads as 0 and ignores writes
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- wr  input  ADDR_W  write address
- wrd  input  WIDTH  write data
- we  input  1  write enable
- clr_req  input  1  request full-array clear (sampled in IDLE only)
- rd1  output  WIDTH  read data, port 1 (combinational)
- rd2  output  WIDTH  read data, port 2 (combinational)
- busy  output  1  clear in progress; writes dropped, reads forced 0
- clr_done  output  1  one-cycle pulse on completion of a clear

## Operation
- State: IDLE, CLEAR; clear pointer ptr (ADDR_W bits).
- rst=1 at an edge: state<=CLEAR, ptr<=0, clr_done<=0; no array write. Holding rst keeps ptr at 0.
- CLEAR, rst=0: mem[ptr]<=0; if ptr==DEPTH-1 then state<=IDLE, clr_done<=1, else ptr<=ptr+1. we and clr_req ignored.
- IDLE, clr_req=1: state<=CLEAR, ptr<=0; a write presented the same cycle is dropped (clear has priority).
- IDLE, clr_req=0, we=1, wr<DEPTH, not (ZERO_R0 and wr==0): mem[wr]<=wrd.
- Writes to wr>=DEPTH are silently dropped.
- Read port n (identical for both): if busy -> 0; else if ra>=DEPTH -> 0; else if ZERO_R0 and ra==0 -> 0; else if BYPASS and we and !clr_req and wr==ra -> wrd; else mem[ra].
- Both ports may address the same entry; both return the same value.
- busy = (state==CLEAR). clr_done is registered, high for exactly one cycle after the final clearing edge.

## Timing
- Reset values: state CLEAR, ptr 0, busy 1, clr_done 0, rd1/rd2 0. Array contents undefined until the clear finishes.
- Clear latency: busy stays high for exactly DEPTH cycles after the first edge with rst=0; clr_done rises on the same edge busy falls.
- Reset mid-clear restarts at ptr=0 (full DEPTH cycles again).
- Write latency: data presented with we at edge k is readable from mem after edge k; with BYPASS=1 it is also visible combinationally during cycle k.
- BYPASS=0: read of wr during its write cycle returns the old value.
- Read path purely combinational from ra/mem/bypass; no registered outputs.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 -> busy=1 for 7 cycles, clr_done pulses once, then rd1=rd2=0 for every address 0..7.
- Write/read: write 0x1ABCD to r3 and 0x00001 to r5, set ra1=3, ra2=5 -> rd1=0x1ABCD, rd2=0x00001; ra1=7 (>=DEPTH) -> rd1=0, and a write to r7 leaves all reads unchanged.
- Bypass: BYPASS=1, we=1, wr=2, wrd=0x15555, ra1=2 in the same cycle -> rd1=0x15555 before the edge; BYPASS=0 -> rd1 shows the old r2 value until after the edge.
- clr_req with write: fill r0..r6 with nonzero values, assert clr_req with we=1, wr=4 -> the write is dropped, busy for 7 cycles, all reads 0 afterward; clr_req pulsed while busy does not extend the clear.
- Reset mid-clear: assert rst at ptr=3 -> ptr returns to 0; busy lasts a full 7 cycles after rst falls.
- ZERO_R0=1, WIDTH=32, DEPTH=16, ADDR_W=4: write 0xFFFFFFFF to r0 and r15 -> r0 reads 0, r15 reads 0xFFFFFFFF; the clear takes 16 cycles.
